// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD arithmetic blocks.
// Holds the digit width, the largest legal digit value, the serial
// subtractor FSM states, a single-digit result type and a digit
// validity helper.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_sub_state_t;

  // One decimal digit of a result together with its borrow
  typedef struct packed {
    logic             borrow;
    logic [BCD_W-1:0] digit;
  } bcd_digit_res_t;

  // A digit code above 9 is not a BCD digit
  function automatic logic bcd_digit_invalid(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtractor: digit = a - b - bin with decimal borrow.
// Purely combinational.
// The invalid output exists only when BCD_SUB_CHECK_EN is defined.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             bin,
`ifdef BCD_SUB_CHECK_EN
  output logic             invalid,
`endif
  output logic [BCD_W-1:0] digit,
  output logic             bout
);

  logic [4:0]     t_s;
  bcd_digit_res_t res_s;

  // Binary difference; a negative result wraps back into 0..9 by adding ten
  always_comb begin
    t_s = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
    if (t_s[4]) begin
      res_s.digit  = t_s[3:0] + 4'd10;
      res_s.borrow = 1'b1;
    end else begin
      res_s.digit  = t_s[3:0];
      res_s.borrow = 1'b0;
    end
  end

  assign digit = res_s.digit;
  assign bout  = res_s.borrow;

`ifdef BCD_SUB_CHECK_EN
  assign invalid = bcd_digit_invalid(a) | bcd_digit_invalid(b);
`endif

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin (mod 10^DIGITS).
// It handles one digit per clock, least significant digit first.
// A negative result is given in ten's complement, with bout set.
// Define BCD_SUB_CHECK_EN to flag input digits above 9 on err.
// Without that macro, err is tied to 0.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  bout,
  output logic                  err
);

  localparam int             W    = BCD_W * DIGITS;
  localparam int             CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIGITS - 1);

  bcd_sub_state_t state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   diff_q, diff_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           borrow_q, borrow_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           bout_q, bout_d;

  logic [BCD_W-1:0] dig_s;
  logic             dig_bout_s;
  logic [W-1:0]     res_shift_s;

`ifdef BCD_SUB_CHECK_EN
  logic invalid_s;
  logic err_acc_q, err_acc_d;
  logic err_q, err_d;
`endif

  bcd_digit_sub u_digit (
    .a       (a_q[BCD_W-1:0]),
    .b       (b_q[BCD_W-1:0]),
    .bin     (borrow_q),
`ifdef BCD_SUB_CHECK_EN
    .invalid (invalid_s),
`endif
    .digit   (dig_s),
    .bout    (dig_bout_s)
  );

  // Result register contents after shifting the current digit in from the top
  always_comb begin
    res_shift_s = res_q >> BCD_W;
    res_shift_s[W-1 -: BCD_W] = dig_s;
  end

  // Next-state, datapath and output decode; an accepted start reloads everything
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef BCD_SUB_CHECK_EN
    err_acc_d = err_acc_q;
    err_d     = err_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = {CW{1'b0}};
          res_d    = {W{1'b0}};
`ifdef BCD_SUB_CHECK_EN
          err_acc_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d      = a_q >> BCD_W;
        b_d      = b_q >> BCD_W;
        res_d    = res_shift_s;
        borrow_d = dig_bout_s;
`ifdef BCD_SUB_CHECK_EN
        err_acc_d = err_acc_q | invalid_s;
`endif
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = res_shift_s;
          bout_d  = dig_bout_s;
`ifdef BCD_SUB_CHECK_EN
          err_d   = err_acc_q | invalid_s;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      res_q    <= {W{1'b0}};
      diff_q   <= {W{1'b0}};
      cnt_q    <= {CW{1'b0}};
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bout_q   <= bout_d;
    end
  end

`ifdef BCD_SUB_CHECK_EN
  // Sticky invalid-digit flag and its held copy presented on err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_acc_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_acc_q <= err_acc_d;
      err_q     <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor with DIGITS=4.
// Directed cases come first, then randomized operations.
// Every result is compared against an arithmetic reference model.
module tb_bcd_serial_subtractor;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst, start, bin;
  logic [15:0]   a, b;
  logic          busy, done, bout, err;
  logic [15:0]   diff;

  int errors = 0;
  int checks = 0;

  logic [15:0] prev_diff;
  logic        prev_bout, prev_err;

  bcd_serial_subtractor #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic digits_valid(input logic [15:0] v);
    logic ok = 1'b1;
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = 16'h0000;
    int m = n;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Reference: plain integer subtraction for valid BCD.
  // Digit-by-digit decimal subtraction is used when any code is above 9.
  task automatic ref_sub(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                         output logic [15:0] rd, output logic rb, output logic re);
    int  d;
    int  t;
    logic bw;
    if (digits_valid(ta) && digits_valid(tb)) begin
      d  = bcd2int(ta) - bcd2int(tb) - int'(tbin);
      rb = (d < 0);
      if (d < 0) d = d + 10000;
      rd = int2bcd(d);
      re = 1'b0;
    end else begin
      bw = tbin;
      rd = 16'h0000;
      for (int i = 0; i < D; i++) begin
        t  = int'(ta[4*i +: 4]) - int'(tb[4*i +: 4]) - int'(bw);
        bw = (t < 0);
        if (t < 0) t = t + 10;
        rd[4*i +: 4] = 4'(t);
      end
      rb = bw;
`ifdef BCD_SUB_CHECK_EN
      re = 1'b1;
`else
      re = 1'b0;
`endif
    end
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Starts an operation in the current cycle and runs it to its done cycle.
  // When inject is set, a stray start with new operands is driven mid-run.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin, input bit inject);
    logic [15:0] ed;
    logic        eb, ee;
    ref_sub(ta, tb, tbin, ed, eb, ee);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < D; i++) begin
      check("busy_run", busy, 1'b1);
      check("done_low_run", done, 1'b0);
      check("diff_hold", diff, prev_diff);
      check("bout_hold", bout, prev_bout);
      check("err_hold", err, prev_err);
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      start = (inject && i == 1) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_pulse", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("diff", diff, ed);
    check("bout", bout, eb);
    check("err", err, ee);
    prev_diff = ed; prev_bout = eb; prev_err = ee;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_idle", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("diff_idle_hold", diff, prev_diff);
    check("bout_idle_hold", bout, prev_bout);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_diff"}, diff, 16'h0000);
    check({tag, "_bout"}, bout, 1'b0);
    check({tag, "_err"},  err,  1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000; bin = 1'b0;
    prev_diff = 16'h0000; prev_bout = 1'b0; prev_err = 1'b0;
    #2;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();

    // Directed arithmetic cases
    run_op(16'h0042, 16'h0017, 1'b0, 1'b0);
    check("spec_42_17", diff, 16'h0025);
    idle_cycle();
    run_op(16'h0000, 16'h0001, 1'b0, 1'b0);
    check("spec_0_1_diff", diff, 16'h9999);
    check("spec_0_1_bout", bout, 1'b1);
    idle_cycle();
    run_op(16'h5000, 16'h4999, 1'b1, 1'b0);
    check("spec_borrow_chain", diff, 16'h0000);
    idle_cycle();

    // A start while busy is ignored; a start in the done cycle is accepted.
    run_op(16'h0987, 16'h0123, 1'b0, 1'b1);
    run_op(16'h0100, 16'h0200, 1'b1, 1'b0);
    run_op(16'h9999, 16'h0000, 1'b0, 1'b0);
    idle_cycle();

    // Reset during digit 2 aborts the operation and clears the held outputs
    run_op(16'h0042, 16'h0017, 1'b0, 1'b0);
    idle_cycle();
    a = 16'h7777; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_zero("midreset");
    prev_diff = 16'h0000; prev_bout = 1'b0; prev_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < D + 2; i++) begin
      @(posedge clk); #1;
      check("no_done_after_abort", done, 1'b0);
    end
    run_op(16'h1234, 16'h0234, 1'b0, 1'b0);
    check("spec_after_reset", diff, 16'h1000);
    idle_cycle();

`ifdef BCD_SUB_CHECK_EN
    run_op(16'h00A3, 16'h0001, 1'b0, 1'b0);
    check("spec_err_set", err, 1'b1);
    run_op(16'h0003, 16'h0001, 1'b0, 1'b0);
    check("spec_err_clear", err, 1'b0);
    check("spec_err_next_diff", diff, 16'h0002);
    idle_cycle();
`endif

    // Randomized operations with random gaps and stray starts
    for (int n = 0; n < 30; n++) begin
      run_op(rand_bcd(), rand_bcd(), 1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
